if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC.
- Issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency.
- Drives `Instruction` and `PC` (PC+4) into decode.
- Obeys `freeze` (hazard stall) and `Branch_taken` (redirect plus flush) from downstream.

---
 rtl/arm_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 39 +++
 rtl/if_stage.sv | 140 ++++++++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM-style front end: word width, NOP encoding,
// fetch FSM states and the instruction/PC pair carried into the IF/ID register.
package arm_pkg;

   localparam int WORD_W = 32;

   // MOV r0,r0 with condition AL: architecturally a no-op, used for bubbles and flushes.
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'hE1A0_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } if_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
   } fetch_word_t;

   function automatic logic [WORD_W-1:0] pc_add(input logic [WORD_W-1:0] pc,
                                                 input logic [WORD_W-1:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Update priority: reset > flush > hold > load > bubble.
// Flush and bubble both leave PC untouched and only replace the instruction with a NOP.
module if_id_reg
   import arm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              load,
   input  fetch_word_t       load_word,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pc,
   output logic              valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr <= NOP_INSTR;
         pc    <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (hold) begin
         instr <= instr;
         pc    <= pc;
         valid <= valid;
      end else if (load) begin
         instr <= load_word.instr;
         pc    <= load_word.pc;
         valid <= 1'b1;
      end else begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC ownership, variable-latency imem req/ack, one-entry stall buffer
// and IF/ID register. Optional IF_STAGE_PERF_CNT_EN adds fetch_cnt/stall_cnt outputs.
//
// Memory handshake: imem_req is a level held while a fetch is outstanding; imem_addr is stable
// until imem_ack, a single-cycle pulse qualifying imem_rdata. A request is never withdrawn
// mid-flight, so a redirect during a pending fetch waits in DROP for the stale ack.
module if_stage
   import arm_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [WORD_W-1:0] PC_STEP  = 32'd4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              Branch_taken,
   input  logic [WORD_W-1:0] Branch_addr,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] Instruction,
   output logic [WORD_W-1:0] PC,
   output logic              valid,
   output if_state_t         dbg_state
`ifdef IF_STAGE_PERF_CNT_EN
   ,
   output logic [WORD_W-1:0] fetch_cnt,
   output logic [WORD_W-1:0] stall_cnt
`endif
);

   if_state_t         state, state_nxt;
   logic [WORD_W-1:0] req_pc, req_pc_nxt;
   logic [WORD_W-1:0] target, target_nxt;
   fetch_word_t       buf_q, buf_nxt;
   logic [WORD_W-1:0] pc_inc;
   logic              load;
   fetch_word_t       load_word;

   assign pc_inc    = pc_add(req_pc, PC_STEP);
   assign imem_req  = (state != HOLD);
   assign imem_addr = req_pc;
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FETCH;
         req_pc <= RESET_PC;
         target <= RESET_PC;
         buf_q  <= '0;
      end else begin
         state  <= state_nxt;
         req_pc <= req_pc_nxt;
         target <= target_nxt;
         buf_q  <= buf_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req_pc_nxt = req_pc;
      target_nxt = target;
      buf_nxt    = buf_q;
      load       = 1'b0;
      load_word  = '0;
      case (state)
         FETCH: begin
            if (imem_ack) begin
               if (Branch_taken) begin
                  req_pc_nxt = Branch_addr;
               end else if (freeze) begin
                  buf_nxt    = '{instr: imem_rdata, pc: pc_inc};
                  req_pc_nxt = pc_inc;
                  state_nxt  = HOLD;
               end else begin
                  load       = 1'b1;
                  load_word  = '{instr: imem_rdata, pc: pc_inc};
                  req_pc_nxt = pc_inc;
               end
            end else if (Branch_taken) begin
               target_nxt = Branch_addr;
               state_nxt  = DROP;
            end
         end
         HOLD: begin
            // The buffer is only meaningful in HOLD, so leaving HOLD empties it.
            if (Branch_taken) begin
               req_pc_nxt = Branch_addr;
               state_nxt  = FETCH;
            end else if (!freeze) begin
               load      = 1'b1;
               load_word = buf_q;
               state_nxt = FETCH;
            end
         end
         DROP: begin
            // A branch arriving together with the stale ack is the newest redirect.
            if (imem_ack) begin
               req_pc_nxt = Branch_taken ? Branch_addr : target;
               state_nxt  = FETCH;
            end else if (Branch_taken) begin
               target_nxt = Branch_addr;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .flush     (Branch_taken),
      .hold      (freeze),
      .load      (load),
      .load_word (load_word),
      .instr     (Instruction),
      .pc        (PC),
      .valid     (valid)
   );

`ifdef IF_STAGE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (load && !Branch_taken && !freeze) begin
            fetch_cnt <= fetch_cnt + 1'b1;
         end
         if ((imem_req && !imem_ack) || (state == HOLD)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a ROM whose word at address A is 32'hA500_0000 + A, answering
// each request in the lat-th cycle it is held (lat=1 gives a same-cycle ack).
module tb_if_stage;
   import arm_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        Branch_taken;
   logic [31:0] Branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic        valid;
   if_state_t   dbg_state;
`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   int mem_cnt;

   always #5 clk = ~clk;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .Branch_taken (Branch_taken),
      .Branch_addr  (Branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .Instruction  (Instruction),
      .PC           (PC),
      .valid        (valid),
      .dbg_state    (dbg_state)
`ifdef IF_STAGE_PERF_CNT_EN
      ,
      .fetch_cnt    (fetch_cnt),
      .stall_cnt    (stall_cnt)
`endif
   );

   // Memory model: counts cycles the current request has waited.
   always @(posedge clk or posedge rst) begin
      if (rst) mem_cnt <= 0;
      else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
   end
   assign imem_ack   = imem_req && (mem_cnt == lat - 1);
   assign imem_rdata = 32'hA500_0000 + imem_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                           input logic v);
      chk({tag, ".instr"}, Instruction, ins);
      chk({tag, ".pc"}, PC, pc);
      chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int l);
      rst = 1'b1;
      freeze = 1'b0;
      Branch_taken = 1'b0;
      Branch_addr = '0;
      lat = l;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // Zero-wait streaming
      do_reset(1);
      chk_ifid("rst", NOP_INSTR, 32'h0, 1'b0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.req", {31'b0, imem_req}, 32'h1);
      chk("rst.state", 32'(dbg_state), 32'(FETCH));
      step();
      chk_ifid("zw0", 32'hA500_0000, 32'h4, 1'b1);
      chk("zw0.addr", imem_addr, 32'h4);
      step();
      chk_ifid("zw1", 32'hA500_0004, 32'h8, 1'b1);
      chk("zw1.addr", imem_addr, 32'h8);
      step();
      chk_ifid("zw2", 32'hA500_0008, 32'hC, 1'b1);
`ifdef IF_STAGE_PERF_CNT_EN
      chk("zw.fetch_cnt", fetch_cnt, 32'd3);
      chk("zw.stall_cnt", stall_cnt, 32'd0);
`endif

      // 3-cycle latency memory
      do_reset(3);
      step();
      chk_ifid("l3a", NOP_INSTR, 32'h0, 1'b0);
      chk("l3a.addr", imem_addr, 32'h0);
      step();
      chk_ifid("l3b", NOP_INSTR, 32'h0, 1'b0);
      chk("l3b.addr", imem_addr, 32'h0);
      chk("l3b.ack", {31'b0, imem_ack}, 32'h1);
      step();
      chk_ifid("l3c", 32'hA500_0000, 32'h4, 1'b1);
      chk("l3c.addr", imem_addr, 32'h4);

      // Freeze for 4 cycles while an ack lands
      do_reset(1);
      step();
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_ifid("frz", 32'hA500_0000, 32'h4, 1'b1);
         chk("frz.req", {31'b0, imem_req}, 32'h0);
         chk("frz.state", 32'(dbg_state), 32'(HOLD));
      end
      freeze = 1'b0;
      step();
      chk_ifid("unfrz0", 32'hA500_0004, 32'h8, 1'b1);
      chk("unfrz0.addr", imem_addr, 32'h8);
      step();
      chk_ifid("unfrz1", 32'hA500_0008, 32'hC, 1'b1);

      // Branch while a 3-cycle fetch of 0x8 is pending
      do_reset(1);
      step();
      step();
      lat = 3;
      Branch_taken = 1'b1;
      Branch_addr = 32'h100;
      step();
      Branch_taken = 1'b0;
      chk_ifid("drop0", NOP_INSTR, 32'h8, 1'b0);
      chk("drop0.addr", imem_addr, 32'h8);
      chk("drop0.state", 32'(dbg_state), 32'(DROP));
      step();
      chk("drop1.addr", imem_addr, 32'h8);
      chk("drop1.ack", {31'b0, imem_ack}, 32'h1);
      step();
      chk("drop2.addr", imem_addr, 32'h100);
      chk_ifid("drop2", NOP_INSTR, 32'h8, 1'b0);
      lat = 1;
      step();
      chk_ifid("tgt", 32'hA500_0100, 32'h104, 1'b1);

      // Branch and freeze together while HOLD has a buffered word
      do_reset(1);
      step();
      freeze = 1'b1;
      step();
      Branch_taken = 1'b1;
      Branch_addr = 32'h200;
      step();
      Branch_taken = 1'b0;
      freeze = 1'b0;
      chk_ifid("bf", NOP_INSTR, 32'h4, 1'b0);
      chk("bf.addr", imem_addr, 32'h200);
      chk("bf.req", {31'b0, imem_req}, 32'h1);
      step();
      chk_ifid("bf1", 32'hA500_0200, 32'h204, 1'b1);

      // Branch coinciding with an ack in FETCH, then PC wrap at the top of memory
      Branch_taken = 1'b1;
      Branch_addr = 32'hFFFF_FFFC;
      step();
      Branch_taken = 1'b0;
      chk_ifid("bak", NOP_INSTR, 32'h204, 1'b0);
      chk("bak.addr", imem_addr, 32'hFFFF_FFFC);
      step();
      chk_ifid("wrap", 32'hA4FF_FFFC, 32'h0, 1'b1);
      chk("wrap.addr", imem_addr, 32'h0);

      // Asynchronous reset in the middle of DROP
      do_reset(1);
      step();
      lat = 3;
      Branch_taken = 1'b1;
      Branch_addr = 32'h40;
      step();
      Branch_taken = 1'b0;
      chk("pre.state", 32'(dbg_state), 32'(DROP));
      chk("pre.addr", imem_addr, 32'h4);
      #2 rst = 1'b1;
      #1;
      chk_ifid("arst", NOP_INSTR, 32'h0, 1'b0);
      chk("arst.addr", imem_addr, 32'h0);
      chk("arst.state", 32'(dbg_state), 32'(FETCH));
`ifdef IF_STAGE_PERF_CNT_EN
      chk("arst.fetch_cnt", fetch_cnt, 32'd0);
      chk("arst.stall_cnt", stall_cnt, 32'd0);
`endif
      lat = 1;
      @(negedge clk);
      rst = 1'b0;
      step();
      chk_ifid("post", 32'hA500_0000, 32'h4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
